// File: rtl/cskipa_seq_ctrl_if.sv
// cskipa_seq_ctrl_if -- bus bundle for the multi-word carry-skip adder sequencer.
//
// Groups two buses:
//   request/result : i_start, i_nwords, i_sub, i_op_a, i_op_b  -> o_ready, o_done, o_result, o_cout
//   adder          : o_adder_a, o_adder_b, o_adder_cin        -> i_adder_sum, i_adder_cout
//
// Handshake: a request is accepted on any rising edge where o_ready=1 and i_start=1;
// i_start is ignored while o_ready=0 (no queuing). o_done is a one-cycle result-valid
// pulse with no backpressure; o_result/o_cout stay stable until the next accept.
// The adder bus is purely combinational: sum/cout answer a/b/cin in the same cycle.
//
// modport slave  : the sequencer (cskipa_seq_ctrl)
// modport master : the requester, which also hosts the external adder
interface cskipa_seq_ctrl_if #(
  parameter int WORD  = 32,
  parameter int NWMAX = 4
);
  logic                    i_start;
  logic [1:0]              i_nwords;
  logic                    i_sub;
  logic [WORD*NWMAX-1:0]   i_op_a;
  logic [WORD*NWMAX-1:0]   i_op_b;
  logic                    o_ready;
  logic                    o_done;
  logic [WORD*NWMAX-1:0]   o_result;
  logic                    o_cout;
  logic [WORD-1:0]         o_adder_a;
  logic [WORD-1:0]         o_adder_b;
  logic                    o_adder_cin;
  logic [WORD-1:0]         i_adder_sum;
  logic                    i_adder_cout;

  modport slave (
    input  i_start, i_nwords, i_sub, i_op_a, i_op_b, i_adder_sum, i_adder_cout,
    output o_ready, o_done, o_result, o_cout, o_adder_a, o_adder_b, o_adder_cin
  );

  modport master (
    output i_start, i_nwords, i_sub, i_op_a, i_op_b, i_adder_sum, i_adder_cout,
    input  o_ready, o_done, o_result, o_cout, o_adder_a, o_adder_b, o_adder_cin
  );
endinterface

// File: rtl/cskipa_seq_ctrl.sv
// cskipa_seq_ctrl -- sequences a multi-word add/subtract through one external
// WORD-bit carry-skip adder, one word per cycle, least significant word first.
//
// Ports:
//   i_clk       : clock, all state updates on rising edge
//   i_rst       : synchronous active-high reset
//   bus         : cskipa_seq_ctrl_if.slave (request/result bus + adder bus)
//   o_dbg_state : current FSM state (0=IDLE, 1=RUN, 2=DONE)
//
// Subtraction is A + ~B + 1: B words are inverted and the first carry-in is 1,
// so a final carry-out of 1 means no borrow.
module cskipa_seq_ctrl #(
  parameter int WORD  = 32,
  parameter int NWMAX = 4
) (
  input  logic              i_clk,
  input  logic              i_rst,
  cskipa_seq_ctrl_if.slave  bus,
  output logic [1:0]        o_dbg_state
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t                  state_q, state_d;
  logic [WORD*NWMAX-1:0]   a_q, b_q;
  logic [1:0]              nwords_q;
  logic                    sub_q;
  logic [1:0]              idx_q;
  logic                    carry_q;
  logic [WORD*NWMAX-1:0]   result_q;
  logic                    cout_q;

  // State register
  always_ff @(posedge i_clk) begin
    if (i_rst) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next state and adder drive
  always_comb begin
    state_d         = state_q;
    bus.o_adder_a   = '0;
    bus.o_adder_b   = '0;
    bus.o_adder_cin = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.i_start) state_d = RUN;
      end
      RUN: begin
        bus.o_adder_a   = a_q[idx_q*WORD +: WORD];
        bus.o_adder_b   = sub_q ? ~b_q[idx_q*WORD +: WORD] : b_q[idx_q*WORD +: WORD];
        // The first word takes the subtract "+1"; later words chain the carry.
        bus.o_adder_cin = (idx_q == 2'd0) ? sub_q : carry_q;
        if (idx_q == nwords_q) state_d = DONE;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Datapath registers
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      a_q      <= '0;
      b_q      <= '0;
      nwords_q <= 2'd0;
      sub_q    <= 1'b0;
      idx_q    <= 2'd0;
      carry_q  <= 1'b0;
      result_q <= '0;
      cout_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.i_start) begin
            a_q      <= bus.i_op_a;
            b_q      <= bus.i_op_b;
            nwords_q <= bus.i_nwords;
            sub_q    <= bus.i_sub;
            idx_q    <= 2'd0;
            result_q <= '0;
            cout_q   <= 1'b0;
          end
        end
        RUN: begin
          result_q[idx_q*WORD +: WORD] <= bus.i_adder_sum;
          carry_q                      <= bus.i_adder_cout;
          // idx stops at nwords_q, so it never wraps past the last word.
          if (idx_q == nwords_q) cout_q <= bus.i_adder_cout;
          else                   idx_q  <= idx_q + 2'd1;
        end
        default: begin
        end
      endcase
    end
  end

  assign bus.o_ready  = (state_q == IDLE);
  assign bus.o_done   = (state_q == DONE);
  assign bus.o_result = result_q;
  assign bus.o_cout   = cout_q;
  assign o_dbg_state  = state_q;

endmodule

// File: tb/tb_cskipa_seq_ctrl.sv
// tb_cskipa_seq_ctrl -- self-checking bench for cskipa_seq_ctrl with a
// behavioural adder on the adder bus and an arithmetic reference model.
module tb_cskipa_seq_ctrl;
  localparam int WORD  = 32;
  localparam int NWMAX = 4;
  localparam int W     = WORD*NWMAX + 1;   // {cout, result}

  // ---------------- clock / reset ----------------
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] dbg_state;
  always #5 clk = ~clk;

  cskipa_seq_ctrl_if #(.WORD(WORD), .NWMAX(NWMAX)) bus ();

  cskipa_seq_ctrl #(.WORD(WORD), .NWMAX(NWMAX)) dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .bus         (bus),
    .o_dbg_state (dbg_state)
  );

  // Behavioural external adder
  always_comb begin
    {bus.i_adder_cout, bus.i_adder_sum} =
      {1'b0, bus.o_adder_a} + {1'b0, bus.o_adder_b} + {{WORD{1'b0}}, bus.o_adder_cin};
  end

  // ---------------- scoreboard ----------------
  int checks   = 0;
  int failures = 0;
  logic [W-1:0] exp_q[$];

  task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Reference: n-word unsigned arithmetic modulo 2^(32n).
  function automatic logic [W-1:0] model(input logic [1:0] nw, input logic sub,
                                         input logic [WORD*NWMAX-1:0] a,
                                         input logic [WORD*NWMAX-1:0] b);
    int           n;
    logic [W-1:0] mask, am, bm, s, res;
    logic         c;
    n    = int'(nw) + 1;
    mask = ({{(W-1){1'b0}}, 1'b1} << (WORD*n)) - 1;
    am   = {1'b0, a} & mask;
    bm   = {1'b0, b} & mask;
    if (!sub) begin
      s   = am + bm;
      res = s & mask;
      c   = s[WORD*n];
    end else begin
      res = (am - bm) & mask;
      c   = (am >= bm);
    end
    return {c, res[W-2:0]};
  endfunction

  function automatic logic [WORD*NWMAX-1:0] rand_wide();
    logic [WORD*NWMAX-1:0] v;
    for (int k = 0; k < NWMAX; k++) begin
      case ($urandom_range(0, 3))
        0:       v[k*WORD +: WORD] = '1;
        1:       v[k*WORD +: WORD] = '0;
        default: v[k*WORD +: WORD] = $urandom;
      endcase
    end
    return v;
  endfunction

  // ---------------- driver ----------------
  // Called at a negedge with the DUT idle; returns at a negedge with the DUT idle.
  task automatic do_op(input string tag, input logic [1:0] nw, input logic sub,
                       input logic [WORD*NWMAX-1:0] a, input logic [WORD*NWMAX-1:0] b);
    logic [W-1:0]    e;
    logic [WORD-1:0] exp_b0;
    int              cnt;
    check({tag, "_ready"}, {{(W-1){1'b0}}, bus.o_ready}, 1);
    bus.i_start  = 1'b1;
    bus.i_nwords = nw;
    bus.i_sub    = sub;
    bus.i_op_a   = a;
    bus.i_op_b   = b;
    e            = model(nw, sub, a, b);
    exp_b0       = sub ? ~b[WORD-1:0] : b[WORD-1:0];
    @(posedge clk);
    @(negedge clk);
    bus.i_start = 1'b0;
    // First RUN cycle: word 0 on the adder bus
    check({tag, "_adder_a0"}, {{(W-WORD){1'b0}}, bus.o_adder_a}, {{(W-WORD){1'b0}}, a[WORD-1:0]});
    check({tag, "_adder_b0"}, {{(W-WORD){1'b0}}, bus.o_adder_b}, {{(W-WORD){1'b0}}, exp_b0});
    check({tag, "_adder_cin0"}, {{(W-1){1'b0}}, bus.o_adder_cin}, {{(W-1){1'b0}}, sub});
    // Scramble inputs mid-operation; they must not matter
    bus.i_nwords = 2'($urandom_range(0, 3));
    bus.i_sub    = 1'($urandom_range(0, 1));
    bus.i_op_a   = rand_wide();
    bus.i_op_b   = rand_wide();
    cnt = 0;
    while (!bus.o_done && cnt < 20) begin
      @(posedge clk);
      cnt++;
      @(negedge clk);
    end
    check({tag, "_latency"}, W'(cnt), W'(int'(nw) + 1));
    check({tag, "_result"}, {bus.o_cout, bus.o_result}, e);
    @(negedge clk);
    check({tag, "_done_pulse"}, {{(W-2){1'b0}}, bus.o_done, bus.o_ready}, 2'b01);
    check({tag, "_held"}, {bus.o_cout, bus.o_result}, e);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [W-1:0] e;
    int           last_acc;
    bus.i_start  = 1'b0;
    bus.i_nwords = 2'd0;
    bus.i_sub    = 1'b0;
    bus.i_op_a   = '0;
    bus.i_op_b   = '0;

    // Reset, with i_start asserted to confirm reset priority
    repeat (3) @(posedge clk);
    @(negedge clk);
    bus.i_start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("rst_ready", {{(W-1){1'b0}}, bus.o_ready}, 1);
    check("rst_done", {{(W-1){1'b0}}, bus.o_done}, 0);
    check("rst_result", {bus.o_cout, bus.o_result}, 0);
    check("rst_adder", {{(W-WORD*2-1){1'b0}}, bus.o_adder_a, bus.o_adder_b, bus.o_adder_cin}, 0);
    bus.i_start = 1'b0;
    rst = 1'b0;

    // Directed cases (first accept on the first edge after reset release)
    do_op("add1", 2'd0, 1'b0, 128'hFFFFFFFF, 128'h1);
    check("add1_value", {bus.o_cout, bus.o_result}, {1'b1, 128'h0});
    do_op("add4", 2'd3, 1'b0, 128'h00000000_FFFFFFFF_FFFFFFFF_FFFFFFFF, 128'h1);
    check("add4_value", {bus.o_cout, bus.o_result}, {1'b0, 128'h00000001_00000000_00000000_00000000});
    do_op("sub2", 2'd1, 1'b1, 128'h0, 128'h1);
    check("sub2_value", {bus.o_cout, bus.o_result}, {1'b0, 128'h00000000_00000000_FFFFFFFF_FFFFFFFF});
    do_op("sub_nb", 2'd1, 1'b1, 128'h5_00000000, 128'h5_00000000);
    check("sub_nb_value", {bus.o_cout, bus.o_result}, {1'b1, 128'h0});

    // i_start held high with 3-word ops: accepts every 5 cycles
    last_acc = -1;
    for (int cyc = 0; cyc < 26; cyc++) begin
      if (bus.o_done) begin
        if (exp_q.size() == 0) check("hold_extra_done", 1, 0);
        else begin
          e = exp_q.pop_front();
          check("hold_result", {bus.o_cout, bus.o_result}, e);
        end
      end
      bus.i_start  = 1'b1;
      bus.i_nwords = 2'd2;
      bus.i_sub    = 1'($urandom_range(0, 1));
      bus.i_op_a   = rand_wide();
      bus.i_op_b   = rand_wide();
      if (bus.o_ready) begin
        exp_q.push_back(model(bus.i_nwords, bus.i_sub, bus.i_op_a, bus.i_op_b));
        if (last_acc >= 0) check("hold_spacing", W'(cyc - last_acc), 5);
        last_acc = cyc;
      end
      @(posedge clk);
      @(negedge clk);
    end
    bus.i_start = 1'b0;
    for (int cyc = 0; cyc < 8; cyc++) begin
      if (bus.o_done && exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("hold_result", {bus.o_cout, bus.o_result}, e);
      end
      @(posedge clk);
      @(negedge clk);
    end
    check("hold_drained", W'(exp_q.size()), 0);

    // Reset during RUN at idx=1 of a 4-word op
    check("rstrun_ready", {{(W-1){1'b0}}, bus.o_ready}, 1);
    bus.i_start  = 1'b1;
    bus.i_nwords = 2'd3;
    bus.i_sub    = 1'b0;
    bus.i_op_a   = rand_wide();
    bus.i_op_b   = rand_wide();
    @(posedge clk);          // accept
    @(negedge clk);
    bus.i_start = 1'b0;
    @(posedge clk);          // idx 0 -> 1
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("rstrun_ready_after", {{(W-1){1'b0}}, bus.o_ready}, 1);
    check("rstrun_done", {{(W-1){1'b0}}, bus.o_done}, 0);
    check("rstrun_result", {bus.o_cout, bus.o_result}, 0);
    rst = 1'b0;
    do_op("after_rst", 2'd0, 1'b0, 128'd5, 128'd7);
    check("after_rst_value", {bus.o_cout, bus.o_result}, W'(12));

    // Randomized operations
    for (int i = 0; i < 40; i++) begin
      logic [1:0] nw;
      logic       sb;
      nw = 2'($urandom_range(0, 3));
      sb = 1'($urandom_range(0, 1));
      do_op("rand", nw, sb, rand_wide(), rand_wide());
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk);
        @(negedge clk);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Global time limit
  initial begin
    #200000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule
